// File: rtl/pocq_sched_pkg.sv
// Shared HN-F definitions for the POCQ scheduler: entry state encoding,
// default queue depth and the request flit layout held by each POCQ slot.
package pocq_sched_pkg;

    localparam int POCQ_DEPTH = 16;

    typedef enum logic [1:0] {
        INVALID = 2'd0,
        SLEEP   = 2'd1,
        READY   = 2'd2,
        ISSUED  = 2'd3
    } pocq_state_e;

    typedef struct packed {
        logic [10:0] txn_id;
        logic [6:0]  opcode;
        logic [47:0] addr;
        logic [6:0]  src_id;
    } reqflit_t;

endpackage

// File: rtl/pocq_sched_if.sv
// POCQ scheduler bus: fill-side alloc/wake, pipeline issue/retry/done, and
// free/occupancy status. master = POCQ fill + pipeline, slave = scheduler.
interface pocq_sched_if
    import pocq_sched_pkg::*;
#(
    parameter int DEPTH = POCQ_DEPTH
);
    localparam int IDXW = $clog2(DEPTH);

    logic              alloc_vld;
    logic [IDXW-1:0]   alloc_idx;
    logic              alloc_sleep;
    logic [DEPTH-1:0]  wake_vec;
    logic              issue_vld;
    logic [IDXW-1:0]   issue_idx;
    logic              issue_rdy;
    logic              retry_vld;
    logic [IDXW-1:0]   retry_idx;
    logic              done_vld;
    logic [IDXW-1:0]   done_idx;
    logic [DEPTH-1:0]  free_vec;
    logic [IDXW:0]     occ;
    logic              full;

    modport master (
        output alloc_vld, alloc_idx, alloc_sleep, wake_vec, issue_rdy,
               retry_vld, retry_idx, done_vld, done_idx,
        input  issue_vld, issue_idx, free_vec, occ, full
    );

    modport slave (
        input  alloc_vld, alloc_idx, alloc_sleep, wake_vec, issue_rdy,
               retry_vld, retry_idx, done_vld, done_idx,
        output issue_vld, issue_idx, free_vec, occ, full
    );

endinterface

// File: rtl/pocq_rr_arb.sv
// Round-robin arbiter: grants the first requester at or above ptr, wrapping
// around. N must be a power of two so the index add wraps naturally.
module pocq_rr_arb #(
    parameter int  N = 16,
    localparam int W = $clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [N-1:0] gnt,
    output logic [W-1:0] idx
);
    logic [W-1:0] cand;
    logic         found;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        cand  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            cand = ptr + W'(k);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
        gnt[idx] = found;
    end

endmodule

// File: rtl/pocq_sched.sv
// POCQ per-entry scheduler: slot lifecycle, issue arbitration with grant lock,
// free vector and occupancy. Define POCQ_SCHED_AGE_EN for oldest-ready issue.
module pocq_sched
    import pocq_sched_pkg::*;
#(
    parameter int  DEPTH = POCQ_DEPTH,
    localparam int IDXW  = $clog2(DEPTH)
) (
    input logic         clk,
    input logic         rst,
    pocq_sched_if.slave bus
);
    localparam int OW = IDXW + 1;

    pocq_state_e      state     [DEPTH];
    pocq_state_e      state_nxt [DEPTH];
    logic [DEPTH-1:0] ready_nxt;
    logic [DEPTH-1:0] free_nxt;
    logic             accept;
    logic             alloc_ok;
    logic             done_ok;
    logic [OW-1:0]    occ_nxt;
    logic             arb_vld;
    logic [IDXW-1:0]  arb_idx;
    logic             alloc_bad;

    assign accept = bus.issue_vld & bus.issue_rdy;

    // Decisions use the state at the start of the cycle, so done beats a
    // same-cycle alloc and wake is ignored for a just-allocated slot.
    always_comb begin
        alloc_ok = 1'b0;
        done_ok  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            state_nxt[i] = state[i];
            case (state[i])
                INVALID: if (bus.alloc_vld && bus.alloc_idx == IDXW'(i)) begin
                    state_nxt[i] = bus.alloc_sleep ? SLEEP : READY;
                    alloc_ok     = 1'b1;
                end
                SLEEP:   if (bus.wake_vec[i]) state_nxt[i] = READY;
                READY:   if (accept && bus.issue_idx == IDXW'(i)) state_nxt[i] = ISSUED;
                ISSUED: begin
                    if (bus.done_vld && bus.done_idx == IDXW'(i)) begin
                        state_nxt[i] = INVALID;
                        done_ok      = 1'b1;
                    end else if (bus.retry_vld && bus.retry_idx == IDXW'(i)) begin
                        state_nxt[i] = SLEEP;
                    end
                end
                default: state_nxt[i] = INVALID;
            endcase
            ready_nxt[i] = (state_nxt[i] == READY);
            free_nxt[i]  = (state_nxt[i] == INVALID);
        end
    end

    assign occ_nxt = bus.occ + OW'(alloc_ok) - OW'(done_ok);

`ifdef POCQ_SCHED_AGE_EN
    // age[i][j] = 1: entry i was allocated before entry j.
    logic [DEPTH-1:0] age     [DEPTH];
    logic [DEPTH-1:0] age_nxt [DEPTH];
    logic             blocked;

    always_comb begin
        for (int i = 0; i < DEPTH; i++) age_nxt[i] = age[i];
        if (alloc_ok) begin
            for (int i = 0; i < DEPTH; i++) age_nxt[i][bus.alloc_idx] = 1'b1;
            age_nxt[bus.alloc_idx] = '0;
        end
        arb_vld = 1'b0;
        arb_idx = '0;
        blocked = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready_nxt[j] && age_nxt[j][i]) blocked = 1'b1;
            end
            if (ready_nxt[i] && !blocked && !arb_vld) begin
                arb_vld = 1'b1;
                arb_idx = IDXW'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) age[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) age[i] <= age_nxt[i];
        end
    end
`else
    logic [IDXW-1:0]  rr_ptr;
    logic [IDXW-1:0]  ptr_arb;
    logic [DEPTH-1:0] arb_gnt;

    // Arbitrate with the post-accept pointer so back-to-back issue needs no bubble.
    assign ptr_arb = accept ? bus.issue_idx + IDXW'(1) : rr_ptr;

    pocq_rr_arb #(.N(DEPTH)) u_arb (
        .req (ready_nxt),
        .ptr (ptr_arb),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    assign arb_vld = |arb_gnt;

    always_ff @(posedge clk) begin
        if (!rst)        rr_ptr <= '0;
        else if (accept) rr_ptr <= ptr_arb;
    end
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) state[i] <= INVALID;
            bus.issue_vld <= 1'b0;
            bus.issue_idx <= '0;
            bus.free_vec  <= '1;
            bus.occ       <= '0;
            bus.full      <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) state[i] <= state_nxt[i];
            bus.free_vec <= free_nxt;
            bus.occ      <= occ_nxt;
            bus.full     <= (occ_nxt == OW'(DEPTH));
            if (!bus.issue_vld || bus.issue_rdy) begin
                bus.issue_vld <= arb_vld;
                bus.issue_idx <= arb_idx;
            end
        end
    end

    // A same-cycle done on the slot makes the alloc a legitimate no-op.
    assign alloc_bad = bus.alloc_vld && (state[bus.alloc_idx] != INVALID)
                       && !(bus.done_vld && bus.done_idx == bus.alloc_idx
                            && state[bus.alloc_idx] == ISSUED);

    a_alloc_busy: assert property (@(posedge clk) disable iff (!rst) !alloc_bad);

endmodule

// File: tb/tb_pocq_sched.sv
// Bench for pocq_sched: scenario tasks with inline checks plus an issue
// scoreboard that compares every accepted issue index against expectations.
module tb_pocq_sched;
    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   exp_q [$];

    pocq_sched_if #(.DEPTH(DEPTH)) bus ();

    pocq_sched #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin : mon
        int e;
        if (rst && bus.issue_vld === 1'b1 && bus.issue_rdy === 1'b1) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL issue_unexpected: accepted idx %0d, required no issue", bus.issue_idx);
            end else begin
                e = exp_q.pop_front();
                if (int'(bus.issue_idx) !== e) begin
                    n_bad++;
                    $display("FAIL issue_order: accepted idx %0d, required %0d", bus.issue_idx, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.alloc_vld   = 1'b0;
        bus.alloc_idx   = '0;
        bus.alloc_sleep = 1'b0;
        bus.wake_vec    = '0;
        bus.issue_rdy   = 1'b0;
        bus.retry_vld   = 1'b0;
        bus.retry_idx   = '0;
        bus.done_vld    = 1'b0;
        bus.done_idx    = '0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic alloc(input int idx, input bit sleep);
        bus.alloc_vld   = 1'b1;
        bus.alloc_idx   = 4'(idx);
        bus.alloc_sleep = sleep;
        tick();
        bus.alloc_vld   = 1'b0;
    endtask

    task automatic drained(input string name);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s_drain: %0d issues outstanding, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        n_cmp++;
        if (bus.issue_vld !== 1'b0) begin n_bad++; $display("FAIL rst_hold_vld: got %b, required 0", bus.issue_vld); end
        rst = 1'b1;
        tick();
        n_cmp++;
        if (bus.free_vec !== 16'hFFFF) begin n_bad++; $display("FAIL rst_free: got %h, required ffff", bus.free_vec); end
        n_cmp++;
        if (bus.occ !== 5'd0) begin n_bad++; $display("FAIL rst_occ: got %0d, required 0", bus.occ); end
        n_cmp++;
        if (bus.full !== 1'b0 || bus.issue_vld !== 1'b0 || bus.issue_idx !== 4'd0) begin
            n_bad++;
            $display("FAIL rst_outs: full %b vld %b idx %0d, required 0 0 0", bus.full, bus.issue_vld, bus.issue_idx);
        end
    endtask

    task automatic test_alloc_wake_done();
        do_reset();
        alloc(3, 1'b1);
        n_cmp++;
        if (bus.free_vec !== 16'hFFF7) begin n_bad++; $display("FAIL awd_free: got %h, required fff7", bus.free_vec); end
        n_cmp++;
        if (bus.occ !== 5'd1) begin n_bad++; $display("FAIL awd_occ: got %0d, required 1", bus.occ); end
        n_cmp++;
        if (bus.issue_vld !== 1'b0) begin n_bad++; $display("FAIL awd_sleep_vld: got %b, required 0", bus.issue_vld); end
        bus.wake_vec  = 16'h0008;
        bus.issue_rdy = 1'b1;
        exp_q.push_back(3);
        tick();
        bus.wake_vec = '0;
        n_cmp++;
        if (bus.issue_vld !== 1'b1 || bus.issue_idx !== 4'd3) begin
            n_bad++;
            $display("FAIL awd_offer: vld %b idx %0d, required 1 3", bus.issue_vld, bus.issue_idx);
        end
        tick();
        bus.issue_rdy = 1'b0;
        n_cmp++;
        if (bus.issue_vld !== 1'b0) begin n_bad++; $display("FAIL awd_post_vld: got %b, required 0", bus.issue_vld); end
        bus.done_vld = 1'b1;
        bus.done_idx = 4'd3;
        tick();
        bus.done_vld = 1'b0;
        n_cmp++;
        if (bus.free_vec !== 16'hFFFF || bus.occ !== 5'd0) begin
            n_bad++;
            $display("FAIL awd_done: free %h occ %0d, required ffff 0", bus.free_vec, bus.occ);
        end
        drained("awd");
    endtask

    task automatic test_rr_order();
        int exp_after [4];
        exp_after = '{5, 9, 2, -1};
        do_reset();
        alloc(1, 1'b0);
        alloc(5, 1'b0);
        alloc(9, 1'b0);
        n_cmp++;
        if (bus.issue_vld !== 1'b1 || bus.issue_idx !== 4'd1) begin
            n_bad++;
            $display("FAIL rr_first: vld %b idx %0d, required 1 1", bus.issue_vld, bus.issue_idx);
        end
        bus.issue_rdy = 1'b1;
        exp_q.push_back(1);
        exp_q.push_back(5);
        exp_q.push_back(9);
        exp_q.push_back(2);
        for (int c = 0; c < 4; c++) begin
            if (c == 1) begin
                bus.alloc_vld   = 1'b1;
                bus.alloc_idx   = 4'd2;
                bus.alloc_sleep = 1'b0;
            end
            tick();
            bus.alloc_vld = 1'b0;
            n_cmp++;
            if (exp_after[c] < 0) begin
                if (bus.issue_vld !== 1'b0) begin n_bad++; $display("FAIL rr_cycle%0d: vld %b, required 0", c, bus.issue_vld); end
            end else if (bus.issue_vld !== 1'b1 || int'(bus.issue_idx) !== exp_after[c]) begin
                n_bad++;
                $display("FAIL rr_cycle%0d: vld %b idx %0d, required 1 %0d", c, bus.issue_vld, bus.issue_idx, exp_after[c]);
            end
        end
        bus.issue_rdy = 1'b0;
        drained("rr");
    endtask

    task automatic test_grant_lock();
        do_reset();
        alloc(2, 1'b1);
        alloc(5, 1'b0);
        for (int c = 0; c < 4; c++) begin
            bus.wake_vec = (c == 0) ? 16'h0004 : 16'h0000;
            tick();
            n_cmp++;
            if (bus.issue_vld !== 1'b1 || bus.issue_idx !== 4'd5) begin
                n_bad++;
                $display("FAIL lock_hold%0d: vld %b idx %0d, required 1 5", c, bus.issue_vld, bus.issue_idx);
            end
        end
        bus.wake_vec  = '0;
        bus.issue_rdy = 1'b1;
        exp_q.push_back(5);
        exp_q.push_back(2);
        tick();
        n_cmp++;
        if (bus.issue_vld !== 1'b1 || bus.issue_idx !== 4'd2) begin
            n_bad++;
            $display("FAIL lock_next: vld %b idx %0d, required 1 2", bus.issue_vld, bus.issue_idx);
        end
        tick();
        bus.issue_rdy = 1'b0;
        drained("lock");
    endtask

    task automatic test_retry_done();
        do_reset();
        bus.issue_rdy = 1'b1;
        exp_q.push_back(7);
        alloc(7, 1'b0);
        tick();
        bus.issue_rdy = 1'b0;
        bus.retry_vld = 1'b1;
        bus.retry_idx = 4'd7;
        bus.done_vld  = 1'b1;
        bus.done_idx  = 4'd7;
        tick();
        bus.retry_vld = 1'b0;
        bus.done_vld  = 1'b0;
        n_cmp++;
        if (bus.free_vec !== 16'hFFFF || bus.occ !== 5'd0) begin
            n_bad++;
            $display("FAIL rd_done_wins: free %h occ %0d, required ffff 0", bus.free_vec, bus.occ);
        end
        bus.issue_rdy = 1'b1;
        exp_q.push_back(7);
        alloc(7, 1'b0);
        tick();
        bus.issue_rdy = 1'b0;
        bus.retry_vld = 1'b1;
        bus.retry_idx = 4'd7;
        tick();
        bus.retry_vld = 1'b0;
        n_cmp++;
        if (bus.free_vec !== 16'hFF7F || bus.occ !== 5'd1) begin
            n_bad++;
            $display("FAIL rd_retry: free %h occ %0d, required ff7f 1", bus.free_vec, bus.occ);
        end
        bus.issue_rdy = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_cmp++;
            if (bus.issue_vld !== 1'b0) begin n_bad++; $display("FAIL rd_asleep%0d: vld %b, required 0", c, bus.issue_vld); end
        end
        bus.wake_vec = 16'h0080;
        exp_q.push_back(7);
        tick();
        bus.wake_vec = '0;
        n_cmp++;
        if (bus.issue_vld !== 1'b1 || bus.issue_idx !== 4'd7) begin
            n_bad++;
            $display("FAIL rd_rewake: vld %b idx %0d, required 1 7", bus.issue_vld, bus.issue_idx);
        end
        tick();
        bus.issue_rdy = 1'b0;
        drained("rd");
    endtask

    task automatic test_full();
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(i, 1'b1);
        n_cmp++;
        if (bus.full !== 1'b1 || bus.occ !== 5'd16 || bus.free_vec !== 16'h0000) begin
            n_bad++;
            $display("FAIL full_set: full %b occ %0d free %h, required 1 16 0000", bus.full, bus.occ, bus.free_vec);
        end
        bus.wake_vec  = 16'h0001;
        bus.issue_rdy = 1'b1;
        exp_q.push_back(0);
        tick();
        bus.wake_vec = '0;
        tick();
        bus.issue_rdy   = 1'b0;
        bus.done_vld    = 1'b1;
        bus.done_idx    = 4'd0;
        bus.alloc_vld   = 1'b1;
        bus.alloc_idx   = 4'd0;
        bus.alloc_sleep = 1'b1;
        tick();
        bus.done_vld  = 1'b0;
        bus.alloc_vld = 1'b0;
        n_cmp++;
        if (bus.occ !== 5'd15 || bus.full !== 1'b0 || bus.free_vec !== 16'h0001) begin
            n_bad++;
            $display("FAIL full_done_alloc: occ %0d full %b free %h, required 15 0 0001", bus.occ, bus.full, bus.free_vec);
        end
        drained("full");
    endtask

    task automatic test_mid_reset();
        do_reset();
        alloc(4, 1'b0);
        n_cmp++;
        if (bus.issue_vld !== 1'b1 || bus.issue_idx !== 4'd4) begin
            n_bad++;
            $display("FAIL mrst_offer: vld %b idx %0d, required 1 4", bus.issue_vld, bus.issue_idx);
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++;
        if (bus.issue_vld !== 1'b0 || bus.free_vec !== 16'hFFFF || bus.occ !== 5'd0) begin
            n_bad++;
            $display("FAIL mrst_clear: vld %b free %h occ %0d, required 0 ffff 0", bus.issue_vld, bus.free_vec, bus.occ);
        end
        drained("mrst");
    endtask

    initial begin
        idle();
        test_reset();
        test_alloc_wake_done();
        test_rr_order();
        test_grant_lock();
        test_retry_done();
        test_full();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule

// File: doc/pocq_sched.md
Name: pocq_sched

Overview:
- Per-entry scheduler for the HN-F point-of-coherence queue (POCQ).
- Tracks each POCQ slot's lifecycle: allocation, sleep, wake, issue to the HN-F pipeline, retry and retire.
- Arbitrates among ready entries and issues one entry index per accepted handshake.
- Drives the free-entry vector and occupancy that the POCQ fill logic uses to pick its first free slot.

Parameters:
- DEPTH, 16, number of POCQ entries; must be a power of two, at least 2.
- IDXW, $clog2(DEPTH), entry index width (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset; block is held in reset while rst==0 at posedge clk.
- alloc_vld  in  1  POCQ slot filled this cycle.
- alloc_idx  in  IDXW  slot being filled.
- alloc_sleep  in  1  1: new entry enters SLEEP; 0: enters READY.
- wake_vec  in  DEPTH  per-entry wake pulses (address/resource dependency cleared).
- issue_vld  out  1  an entry index is offered to the pipeline.
- issue_idx  out  IDXW  offered entry index.
- issue_rdy  in  1  pipeline accepts the offered entry.
- retry_vld  in  1  pipeline bounced an issued entry.
- retry_idx  in  IDXW  bounced entry.
- done_vld  in  1  entry retired.
- done_idx  in  IDXW  retired entry.
- free_vec  out  DEPTH  bit i = entry i is INVALID.
- occ  out  IDXW+1  count of non-INVALID entries.
- full  out  1  occ==DEPTH.

Behaviour:
- Reset values:
  - all entries INVALID;
  - free_vec all ones;
  - occ 0, full 0;
  - issue_vld 0, issue_idx 0;
  - grant lock clear;
  - round-robin pointer 0.
- Per-entry state enum {INVALID, SLEEP, READY, ISSUED}; all transitions register at posedge clk.
- INVALID -> SLEEP/READY on alloc_vld with alloc_idx==i, selected by alloc_sleep.
- Alloc to a non-INVALID entry is ignored: state unchanged; simulation assertion fires.
- SLEEP -> READY when wake_vec[i]=1.
- wake_vec bits for entries not in SLEEP are ignored, including an entry allocated in the same cycle.
- READY -> ISSUED on the cycle issue_vld & issue_rdy & issue_idx==i.
- ISSUED -> SLEEP on retry_vld with retry_idx==i. Retry on an entry in any other state is ignored.
- ISSUED -> INVALID on done_vld with done_idx==i. Done on an entry in any other state is ignored.
- Done and retry to the same index in the same cycle: done wins.
- Alloc and done to the same index in the same cycle: alloc is ignored, because the slot was not free at the start of the cycle.
- Issue timing:
  - issue_vld/issue_idx are driven from registers.
  - An entry that becomes READY at edge N can be offered from cycle N at the earliest.
- Grant lock:
  - Once issue_vld=1, issue_idx is held stable until issue_rdy=1.
  - Newly ready entries do not preempt a held offer.
- Arbitration:
  - Round-robin over READY entries, searching from the pointer upward with wrap-around.
  - After an accept, the pointer becomes issue_idx+1 mod DEPTH.
  - Throughput: one issue per cycle when issue_rdy is held high and READY entries exist.
- free_vec, occ and full are registered and reflect the state after the current edge.
- occ arithmetic: +1 per accepted alloc, -1 per accepted done; both in one cycle leaves it unchanged. occ never exceeds DEPTH.
- A reset asserted mid-operation discards all state, including a held offer, within one cycle.

Optional Feature:
- Macro: POCQ_SCHED_AGE_EN.
- Defined:
  - an age matrix (DEPTH x DEPTH bits) records relative allocation order;
  - arbitration picks the oldest READY entry;
  - the round-robin pointer is removed;
  - a retried entry keeps its original age.
- Undefined: round-robin arbitration as above, with no age storage.

Decomposition:
- Shared HN-F package holds reqflit_t, the pocq_state_e enum {INVALID, SLEEP, READY, ISSUED}, and the POCQ_DEPTH constant.
- One sub-module: pocq_rr_arb, a parameterised round-robin arbiter.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and encoded index.
  - When POCQ_SCHED_AGE_EN is defined it is replaced by inline age-matrix logic.

Test Plan:
- Reset with rst=0 for 2 cycles, then release -> free_vec=16'hFFFF, occ=0, issue_vld=0.
- Alloc idx3 with alloc_sleep=1; next cycle wake_vec[3]=1; issue_rdy=1 -> issue_vld with issue_idx=3, then done idx3 -> free_vec[3]=1, occ=0.
- Entries 1, 5, 9 READY and issue_rdy=1 continuously -> issue order 1, 5, 9 on consecutive cycles; alloc 2 after 5 is issued -> issued after 9, wrapping correctly.
- Offer idx5 with issue_rdy=0 for 4 cycles while entry 2 wakes -> issue_idx stays 5 until accepted.
- Issued idx7 gets retry_vld and done_vld in the same cycle -> entry 7 INVALID; separately, retry alone -> SLEEP, and no re-issue until wake_vec[7].
- Alloc all 16 entries -> full=1, occ=16; done one entry while allocating that same index in the same cycle -> alloc ignored, occ=15.
